// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Two-requester AXI read arbiter. Requester 0 (IM side) and requester 1
// (DM side) share one master-side AR/R channel pair. One burst is in flight
// at a time. Grants are round-robin. R beats are routed back to the granted
// requester. A beat counter flags bursts whose RLAST does not agree with ARLEN.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   AR*_0 / AR*_1             requester read-address channels (ARREADY_x out)
//   R*_0 / R*_1               routed read-data channels (RREADY_x in)
//   AR*_M                     registered read-address payload to the interface
//   ARVALID_M / ARREADY_M     master-side AR handshake
//   R*_M / RVALID_M / RREADY_M master-side read-data channel
//   len_err                   one-cycle pulse on a burst length mismatch
module axi_rd_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_BITS-1:0]   ARID_0,
  input  logic [ADDR_BITS-1:0] ARADDR_0,
  input  logic [LEN_BITS-1:0]  ARLEN_0,
  input  logic [SIZE_BITS-1:0] ARSIZE_0,
  input  logic [1:0]           ARBURST_0,
  input  logic                 ARVALID_0,
  output logic                 ARREADY_0,
  input  logic [ID_BITS-1:0]   ARID_1,
  input  logic [ADDR_BITS-1:0] ARADDR_1,
  input  logic [LEN_BITS-1:0]  ARLEN_1,
  input  logic [SIZE_BITS-1:0] ARSIZE_1,
  input  logic [1:0]           ARBURST_1,
  input  logic                 ARVALID_1,
  output logic                 ARREADY_1,
  output logic [ID_BITS-1:0]   RID_0,
  output logic [DATA_BITS-1:0] RDATA_0,
  output logic [1:0]           RRESP_0,
  output logic                 RLAST_0,
  output logic                 RVALID_0,
  input  logic                 RREADY_0,
  output logic [ID_BITS-1:0]   RID_1,
  output logic [DATA_BITS-1:0] RDATA_1,
  output logic [1:0]           RRESP_1,
  output logic                 RLAST_1,
  output logic                 RVALID_1,
  input  logic                 RREADY_1,
  output logic [ID_BITS-1:0]   ARID_M,
  output logic [ADDR_BITS-1:0] ARADDR_M,
  output logic [LEN_BITS-1:0]  ARLEN_M,
  output logic [SIZE_BITS-1:0] ARSIZE_M,
  output logic [1:0]           ARBURST_M,
  output logic                 ARVALID_M,
  input  logic                 ARREADY_M,
  input  logic [ID_BITS-1:0]   RID_M,
  input  logic [DATA_BITS-1:0] RDATA_M,
  input  logic [1:0]           RRESP_M,
  input  logic                 RLAST_M,
  input  logic                 RVALID_M,
  output logic                 RREADY_M,
  output logic                 len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 grant_q, grant_d;
  logic [LEN_BITS-1:0]  exp_len_q, exp_len_d;
  logic [LEN_BITS:0]    cnt_q, cnt_d;
  logic [ID_BITS-1:0]   arid_q, arid_d;
  logic [ADDR_BITS-1:0] araddr_q, araddr_d;
  logic [LEN_BITS-1:0]  arlen_q, arlen_d;
  logic [SIZE_BITS-1:0] arsize_q, arsize_d;
  logic [1:0]           arburst_q, arburst_d;
  logic                 len_err_q, len_err_d;

  logic gnt_s;
  logic accept_s;
  logic in_data_s;
  logic r_hs_s;
  logic at_len_s;

  // Arbitration and zero-latency AR accept while idle.
  always_comb begin
    gnt_s = 1'b0;
    if (ARVALID_0 && ARVALID_1) begin
      gnt_s = prio_q;
    end else if (ARVALID_1) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    accept_s  = (state_q == IDLE) && (ARVALID_0 || ARVALID_1);
    ARREADY_0 = accept_s && !gnt_s;
    ARREADY_1 = accept_s && gnt_s;
  end

  // R channel pass-through to the granted requester; others see zeros.
  always_comb begin
    in_data_s = (state_q == DATA);
    RREADY_M  = in_data_s ? (grant_q ? RREADY_1 : RREADY_0) : 1'b0;
    r_hs_s    = in_data_s && RVALID_M && RREADY_M;
    // cnt_q holds beats already accepted, so the final beat arrives when
    // it equals the expected ARLEN.
    at_len_s  = (cnt_q == {1'b0, exp_len_q});

    RVALID_0 = 1'b0;
    RID_0    = {ID_BITS{1'b0}};
    RDATA_0  = {DATA_BITS{1'b0}};
    RRESP_0  = 2'b00;
    RLAST_0  = 1'b0;
    RVALID_1 = 1'b0;
    RID_1    = {ID_BITS{1'b0}};
    RDATA_1  = {DATA_BITS{1'b0}};
    RRESP_1  = 2'b00;
    RLAST_1  = 1'b0;
    if (in_data_s && !grant_q) begin
      RVALID_0 = RVALID_M;
      RID_0    = RID_M;
      RDATA_0  = RDATA_M;
      RRESP_0  = RRESP_M;
      RLAST_0  = RLAST_M;
    end else if (in_data_s && grant_q) begin
      RVALID_1 = RVALID_M;
      RID_1    = RID_M;
      RDATA_1  = RDATA_M;
      RRESP_1  = RRESP_M;
      RLAST_1  = RLAST_M;
    end else begin
      RVALID_0 = 1'b0;
    end
  end

  // Next-state, payload capture, beat counting and length checking.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant_d   = grant_q;
    exp_len_d = exp_len_q;
    cnt_d     = cnt_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = ADDR;
          grant_d   = gnt_s;
          prio_d    = !gnt_s;
          cnt_d     = {(LEN_BITS+1){1'b0}};
          arid_d    = gnt_s ? ARID_1    : ARID_0;
          araddr_d  = gnt_s ? ARADDR_1  : ARADDR_0;
          arlen_d   = gnt_s ? ARLEN_1   : ARLEN_0;
          arsize_d  = gnt_s ? ARSIZE_1  : ARSIZE_0;
          arburst_d = gnt_s ? ARBURST_1 : ARBURST_0;
          exp_len_d = gnt_s ? ARLEN_1   : ARLEN_0;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (ARREADY_M) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (r_hs_s) begin
          cnt_d     = cnt_q + {{LEN_BITS{1'b0}}, 1'b1};
          len_err_d = (RLAST_M && !at_len_s) || (at_len_s && !RLAST_M);
          // A missing RLAST keeps the burst open until RLAST finally arrives.
          if (RLAST_M) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 1'b0;
      exp_len_q <= {LEN_BITS{1'b0}};
      cnt_q     <= {(LEN_BITS+1){1'b0}};
      arid_q    <= {ID_BITS{1'b0}};
      araddr_q  <= {ADDR_BITS{1'b0}};
      arlen_q   <= {LEN_BITS{1'b0}};
      arsize_q  <= {SIZE_BITS{1'b0}};
      arburst_q <= 2'b00;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      exp_len_q <= exp_len_d;
      cnt_q     <= cnt_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      len_err_q <= len_err_d;
    end
  end

  assign ARVALID_M = (state_q == ADDR);
  assign ARID_M    = arid_q;
  assign ARADDR_M  = araddr_q;
  assign ARLEN_M   = arlen_q;
  assign ARSIZE_M  = arsize_q;
  assign ARBURST_M = arburst_q;
  assign len_err   = len_err_q;

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester read arbiter: IM-side (requester 0) and DM-side (requester 1) AR/R ports share one master-side AR/R channel pair into the master clock-domain interface FIFOs.
- Single clock domain, on the master side of the async AXI interface.
- One read burst in flight at a time; round-robin grant; R beats routed back to the granted requester.
- Burst-length checker flags RLAST/ARLEN mismatches.

Parameters:
- ID_BITS, 4, AR/R ID width.
- ADDR_BITS, 32, address width.
- LEN_BITS, 4, burst length width (beats = ARLEN+1).
- SIZE_BITS, 3, ARSIZE width.
- DATA_BITS, 32, RDATA width.

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous active-high reset.
- ARID_0/ARID_1  input  ID_BITS  requester AR ID.
- ARADDR_0/ARADDR_1  input  ADDR_BITS  requester AR address.
- ARLEN_0/ARLEN_1  input  LEN_BITS  requester burst length.
- ARSIZE_0/ARSIZE_1  input  SIZE_BITS  requester beat size.
- ARBURST_0/ARBURST_1  input  2  requester burst type.
- ARVALID_0/ARVALID_1  input  1  requester AR valid.
- ARREADY_0/ARREADY_1  output  1  requester AR accepted.
- RID_0/RID_1  output  ID_BITS  routed RID.
- RDATA_0/RDATA_1  output  DATA_BITS  routed RDATA.
- RRESP_0/RRESP_1  output  2  routed RRESP.
- RLAST_0/RLAST_1  output  1  routed RLAST.
- RVALID_0/RVALID_1  output  1  routed RVALID.
- RREADY_0/RREADY_1  input  1  requester R ready.
- ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M  output  ID/ADDR/LEN/SIZE/2  registered AR payload to interface.
- ARVALID_M  output  1  AR valid to interface.
- ARREADY_M  input  1  interface AR ready.
- RID_M, RDATA_M, RRESP_M, RLAST_M  input  ID/DATA/2/1  R payload from interface.
- RVALID_M  input  1  R valid from interface.
- RREADY_M  output  1  R ready to interface.
- len_err  output  1  one-cycle pulse on burst length mismatch.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, prio=0 (requester 0 favoured).
  - Beat counter cleared; AR payload registers cleared.
  - All ARREADY_x, RVALID_x, ARVALID_M, RREADY_M and len_err are 0.
  - Reset mid-burst abandons the burst without completing handshakes.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrates combinationally. Only one ARVALID_x high: grant it. Both high: grant the requester prio points to.
  - ARREADY_g=1 in the same cycle (zero-latency accept); other ARREADY=0.
  - At the clock edge: latch payload into AR*_M registers, latch g and expected length ARLEN_g, clear beat counter, set prio=~g, go to ADDR.
  - No ARVALID_x high: stay in IDLE with all ARREADY_x=0.
- ADDR:
  - ARVALID_M=1 with stable payload until ARVALID_M & ARREADY_M; then go to DATA.
  - ARREADY_x=0 throughout.
- DATA:
  - Combinational pass-through: RVALID_g=RVALID_M; RREADY_M=RREADY_g; R*_g=R*_M. Non-granted RVALID=0.
  - Each R handshake increments the beat counter.
  - On handshake with RLAST_M=1: return to IDLE next cycle. Next grant earliest one cycle after the last beat (IDLE cycle).
  - RID and RRESP pass through unchecked; routing is by grant, not by ID.
- Routed R outputs when not granted or not in DATA: RVALID=0; data fields=0.
- len_err pulses 1 cycle after:
  - a handshake with RLAST_M=1 and counter != expected ARLEN; or
  - a handshake with counter == expected ARLEN and RLAST_M=0.
  - On a missing RLAST the burst does not terminate: the block keeps forwarding and waits for RLAST.
- Counter width is LEN_BITS+1; it does not wrap for legal bursts up to 16 beats.
- Round-robin fairness: with both requesters continuously requesting, grants alternate 0,1,0,1...
- Throughput: one beat per cycle when RVALID_M and RREADY_g are held high.

Test Plan:
- Single request: after reset, ARVALID_0=1, ARADDR_0=0x0000_1000, ARLEN_0=3.
  - ARREADY_0=1 in the same cycle; ARVALID_M=1 next cycle with ARADDR_M=0x1000, ARLEN_M=3.
  - 4 R beats routed to port 0 with RLAST_0 on beat 4; RVALID_1 stays 0; len_err=0.
- Contention: ARVALID_0=ARVALID_1=1 continuously for 4 single-beat bursts -> grant order 0,1,0,1; each grant exactly one cycle after the previous RLAST handshake.
- Backpressure:
  - ARREADY_M=0 for 5 cycles -> ARVALID_M and payload stable for those 5 cycles.
  - RREADY_1 toggling during a 4-beat burst to requester 1 -> RREADY_M mirrors it; no beat lost or duplicated.
- Length error:
  - ARLEN=3 with RLAST_M on beat 2 -> len_err pulses once; state returns to IDLE.
  - ARLEN=1 with RLAST_M on beat 3 -> len_err pulses after beat 2; burst ends at beat 3.
- Reset mid-burst: rst=1 during DATA beat 2 -> next cycle all outputs 0, state IDLE, prio=0; a new ARVALID_1 request is granted normally.
